// File: rtl/accumulator_multi_mode.sv
// Multi-cycle slice accumulator: load/add/sub of a zero-extended operand, one op per Run press,
// sticky carry/borrow, optional saturation, Busy/Done handshake.
module accumulator_multi_mode #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned IN_WIDTH = 10,
  parameter int unsigned CHUNK    = 4,
  parameter int unsigned SATURATE = 0
) (
  input  logic                Clk,
  input  logic                Reset_Clear,
  input  logic                Run,
  input  logic                Clear,
  input  logic [1:0]          Mode,
  input  logic [IN_WIDTH-1:0] Din,
  output logic [WIDTH-1:0]    Acc,
  output logic                Carry,
  output logic                Busy,
  output logic                Done
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned K_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SH_W = $clog2(WIDTH) + 1;
  localparam logic [1:0] MODE_LOAD = 2'b00;
  localparam logic [1:0] MODE_ADD  = 2'b01;
  localparam logic [1:0] MODE_SUB  = 2'b10;
  localparam logic [WIDTH-1:0] SLICE_MASK = (WIDTH'(1) << CHUNK) - WIDTH'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE, ST_WAIT_REL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, shadow_q, shadow_d, op_q, op_d;
  logic             carry_q, carry_d, cy_q, cy_d, sub_q, sub_d, run_q;
  logic             busy_q, busy_d, done_q, done_d;
  logic [K_W-1:0]   k_q, k_d;
  logic             start_c, last_c, flag_c;
  logic [SH_W-1:0]  sh_c;
  logic [CHUNK-1:0] a_sl_c, b_sl_c;
  logic [CHUNK:0]   sum_c;
  logic [WIDTH-1:0] din_ext_c;

  assign start_c   = Run & ~run_q;
  assign last_c    = (k_q == K_W'(N - 1));
  assign din_ext_c = WIDTH'(Din);
  assign sh_c      = SH_W'(32'(k_q) * CHUNK);
  assign a_sl_c    = CHUNK'(acc_q >> sh_c);
  assign b_sl_c    = CHUNK'(op_q >> sh_c);
  assign sum_c     = (CHUNK+1)'(a_sl_c) + (CHUNK+1)'(b_sl_c) + (CHUNK+1)'(cy_q);

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset_Clear) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // Next-state logic; Clear aborts any operation
  always_comb begin
    state_d = state_q;
    if (Clear) begin
      state_d = Run ? ST_WAIT_REL : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (start_c) state_d = (Mode == MODE_ADD || Mode == MODE_SUB) ? ST_CALC : ST_DONE;
        ST_CALC:     if (last_c) state_d = ST_DONE;
        ST_DONE:     state_d = Run ? ST_WAIT_REL : ST_IDLE;
        ST_WAIT_REL: if (!Run) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Handshake outputs are decoded from the upcoming state and registered
  always_comb begin
    busy_d = (state_d == ST_CALC) || (state_d == ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  // Datapath: operand latch, slice-serial add into shadow, commit on entry to DONE
  always_comb begin
    acc_d    = acc_q;
    carry_d  = carry_q;
    shadow_d = shadow_q;
    op_d     = op_q;
    cy_d     = cy_q;
    sub_d    = sub_q;
    k_d      = k_q;
    flag_c   = 1'b0;
    if (Clear) begin
      acc_d    = '0;
      carry_d  = 1'b0;
      shadow_d = '0;
      k_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_c) begin
            sub_d    = (Mode == MODE_SUB);
            op_d     = (Mode == MODE_SUB) ? ~din_ext_c : din_ext_c;
            cy_d     = (Mode == MODE_SUB);
            k_d      = '0;
            shadow_d = '0;
            if (Mode == MODE_LOAD) begin
              acc_d   = din_ext_c;
              carry_d = 1'b0;
            end
          end
        end
        ST_CALC: begin
          shadow_d = (shadow_q & ~(SLICE_MASK << sh_c)) | (WIDTH'(sum_c[CHUNK-1:0]) << sh_c);
          cy_d     = sum_c[CHUNK];
          k_d      = last_c ? '0 : k_q + K_W'(1);
          if (last_c) begin
            // Subtract borrows when the final carry-out is clear
            flag_c  = sub_q ? ~sum_c[CHUNK] : sum_c[CHUNK];
            carry_d = carry_q | flag_c;
            if (SATURATE != 0 && flag_c) acc_d = sub_q ? '0 : '1;
            else                         acc_d = shadow_d;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; Run history resets high so a held Run is not seen as an edge
  always_ff @(posedge Clk) begin
    if (!Reset_Clear) begin
      acc_q    <= '0;
      carry_q  <= 1'b0;
      shadow_q <= '0;
      op_q     <= '0;
      cy_q     <= 1'b0;
      sub_q    <= 1'b0;
      k_q      <= '0;
      run_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      shadow_q <= shadow_d;
      op_q     <= op_d;
      cy_q     <= cy_d;
      sub_q    <= sub_d;
      k_q      <= k_d;
      run_q    <= Run;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Acc   = acc_q;
  assign Carry = carry_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_accumulator_multi_mode.sv
// Bench for accumulator_multi_mode: wrap and saturate instances driven in lockstep, checked
// against a vector table, directed sequences and a cycle-count reference model.
module tb_accumulator_multi_mode;

  localparam int unsigned W   = 16;
  localparam int unsigned IW  = 10;
  localparam int unsigned CH  = 4;
  localparam int unsigned NSL = W / CH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, run, clr;
  logic [1:0]    mode;
  logic [IW-1:0] din;
  logic [W-1:0]  acc0, acc1;
  logic          car0, car1, busy0, busy1, done0, done1;

  accumulator_multi_mode #(.WIDTH(W), .IN_WIDTH(IW), .CHUNK(CH), .SATURATE(0)) dut0 (
    .Clk(clk), .Reset_Clear(rst_n), .Run(run), .Clear(clr), .Mode(mode), .Din(din),
    .Acc(acc0), .Carry(car0), .Busy(busy0), .Done(done0));

  accumulator_multi_mode #(.WIDTH(W), .IN_WIDTH(IW), .CHUNK(CH), .SATURATE(1)) dut1 (
    .Clk(clk), .Reset_Clear(rst_n), .Run(run), .Clear(clr), .Mode(mode), .Din(din),
    .Acc(acc1), .Carry(car1), .Busy(busy1), .Done(done1));

  int total = 0;
  int bad   = 0;

  // Reference model: accumulator values plus "cycles left until the op completes"
  int         m_acc [2];
  bit         m_car [2];
  int         left;
  bit         m_prev;
  bit         e_done;
  logic [1:0] pm;
  int         pd;

  typedef struct {
    logic          rst, run, clr;
    logic [1:0]    mode;
    logic [IW-1:0] din;
    logic [W-1:0]  acc;
    logic          car, busy, done;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_op(input int s);
    int sum;
    case (pm)
      2'd0: begin m_acc[s] = pd; m_car[s] = 1'b0; end
      2'd1: begin
        sum = m_acc[s] + pd;
        if (sum > 'hFFFF) begin
          m_car[s] = 1'b1;
          m_acc[s] = (s == 1) ? 'hFFFF : sum - 'h10000;
        end else m_acc[s] = sum;
      end
      2'd2: begin
        if (pd > m_acc[s]) begin
          m_car[s] = 1'b1;
          m_acc[s] = (s == 1) ? 0 : m_acc[s] - pd + 'h10000;
        end else m_acc[s] = m_acc[s] - pd;
      end
      default: ;
    endcase
  endtask

  task automatic model_edge(input logic r, input logic ru, input logic cl,
                            input logic [1:0] md, input logic [IW-1:0] d);
    bit start;
    if (!r) begin
      for (int s = 0; s < 2; s++) begin m_acc[s] = 0; m_car[s] = 1'b0; end
      left = 0; m_prev = 1'b1; e_done = 1'b0;
    end else begin
      start  = ru && !m_prev && (left == 0) && !cl;
      e_done = 1'b0;
      if (cl) begin
        left = 0;
        for (int s = 0; s < 2; s++) begin m_acc[s] = 0; m_car[s] = 1'b0; end
      end else begin
        if (left > 0) left--;
        if (start) begin
          pm = md; pd = int'(d);
          left = (md == 2'd1 || md == 2'd2) ? NSL + 1 : 1;
        end
        if (left == 1) begin
          e_done = 1'b1;
          for (int s = 0; s < 2; s++) apply_op(s);
        end
      end
      m_prev = ru;
    end
  endtask

  task automatic step(input logic r, input logic ru, input logic cl,
                      input logic [1:0] md, input logic [IW-1:0] d);
    rst_n = r; run = ru; clr = cl; mode = md; din = d;
    @(posedge clk);
    model_edge(r, ru, cl, md, d);
    #1;
    chk("model_acc0",  32'(acc0),  m_acc[0]);
    chk("model_acc1",  32'(acc1),  m_acc[1]);
    chk("model_car0",  32'(car0),  32'(m_car[0]));
    chk("model_car1",  32'(car1),  32'(m_car[1]));
    chk("model_busy0", 32'(busy0), 32'(left > 0));
    chk("model_busy1", 32'(busy1), 32'(left > 0));
    chk("model_done0", 32'(done0), 32'(e_done));
    chk("model_done1", 32'(done1), 32'(e_done));
  endtask

  // Press Run once and measure cycles from the sampled edge to the Done pulse
  task automatic do_op(input logic [1:0] md, input logic [IW-1:0] d, input int exp_lat, input string tag);
    int lat;
    step(1'b1, 1'b0, 1'b0, md, d);
    step(1'b1, 1'b1, 1'b0, md, d);
    lat = 1;
    while (!done0 && lat < 20) begin
      step(1'b1, 1'b1, 1'b0, md, d);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    step(1'b1, 1'b0, 1'b0, md, d);
  endtask

  initial begin
    int   ndone, nbusy;
    logic r, ru, cl;
    rst_n = 1'b0; run = 1'b1; clr = 1'b0; mode = 2'd0; din = '0;
    for (int s = 0; s < 2; s++) begin m_acc[s] = 0; m_car[s] = 1'b0; end
    left = 0; m_prev = 1'b1; e_done = 1'b0; pm = 2'd0; pd = 0;

    // Reset with Run held, load, then add 0x3FF with operand changed and a Run bounce mid-op
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 2'd1, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd1, 10'h000, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 2'd0, 10'h3FF, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 2'd0, 10'h3FF, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 2'd0, 10'h3FF, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 2'd0, 10'h3FF, 16'h03FF, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 2'd0, 10'h3FF, 16'h03FF, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 2'd1, 10'h3FF, 16'h03FF, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 2'd1, 10'h3FF, 16'h03FF, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 2'd2, 10'h000, 16'h03FF, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 2'd2, 10'h000, 16'h03FF, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 2'd2, 10'h000, 16'h03FF, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 2'd2, 10'h000, 16'h07FE, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 2'd2, 10'h000, 16'h07FE, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 2'd2, 10'h000, 16'h07FE, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].run, tbl[i].clr, tbl[i].mode, tbl[i].din);
      chk($sformatf("tbl%0d_acc0", i),  32'(acc0),  32'(tbl[i].acc));
      chk($sformatf("tbl%0d_acc1", i),  32'(acc1),  32'(tbl[i].acc));
      chk($sformatf("tbl%0d_car0", i),  32'(car0),  32'(tbl[i].car));
      chk($sformatf("tbl%0d_busy0", i), 32'(busy0), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done0", i), 32'(done0), 32'(tbl[i].done));
    end

    // Borrow, no-op and sticky carry
    do_op(2'd0, 10'h001, 1, "load1");
    do_op(2'd2, 10'h002, 5, "sub2");
    chk("sub_acc_wrap", 32'(acc0), 32'h0000FFFF);
    chk("sub_acc_sat",  32'(acc1), 32'h00000000);
    chk("sub_car_wrap", 32'(car0), 32'd1);
    chk("sub_car_sat",  32'(car1), 32'd1);
    do_op(2'd3, 10'h155, 1, "noop");
    chk("noop_acc_wrap", 32'(acc0), 32'h0000FFFF);
    chk("noop_acc_sat",  32'(acc1), 32'h00000000);
    do_op(2'd1, 10'h001, 5, "add1");
    chk("add1_acc_wrap", 32'(acc0), 32'h00000000);
    chk("add1_acc_sat",  32'(acc1), 32'h00000001);
    chk("sticky_wrap",   32'(car0), 32'd1);
    chk("sticky_sat",    32'(car1), 32'd1);

    // Run held high for 20 cycles: exactly one add of 5
    step(1'b1, 1'b0, 1'b0, 2'd1, 10'h005);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 2'd1, 10'h005);
      if (done0) ndone++;
    end
    chk("held_run_dones", 32'(ndone), 32'd1);
    chk("held_run_acc0",  32'(acc0), 32'h00000005);
    chk("held_run_acc1",  32'(acc1), 32'h00000006);
    step(1'b1, 1'b0, 1'b0, 2'd1, 10'h005);

    // Clear in the second CALC cycle, then Run held: no further activity
    step(1'b1, 1'b1, 1'b0, 2'd1, 10'h020);
    step(1'b1, 1'b1, 1'b0, 2'd1, 10'h020);
    step(1'b1, 1'b1, 1'b1, 2'd1, 10'h020);
    chk("clr_acc0",  32'(acc0),  32'd0);
    chk("clr_acc1",  32'(acc1),  32'd0);
    chk("clr_car0",  32'(car0),  32'd0);
    chk("clr_car1",  32'(car1),  32'd0);
    chk("clr_busy0", 32'(busy0), 32'd0);
    nbusy = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 2'd1, 10'h020);
      if (busy0 || done0) nbusy++;
    end
    chk("clr_wait_release", 32'(nbusy), 32'd0);
    step(1'b1, 1'b0, 1'b0, 2'd1, 10'h020);

    // Reset in the third CALC cycle, then a fresh add
    do_op(2'd0, 10'h123, 1, "load123");
    step(1'b1, 1'b1, 1'b0, 2'd1, 10'h007);
    step(1'b1, 1'b1, 1'b0, 2'd1, 10'h007);
    step(1'b1, 1'b1, 1'b0, 2'd1, 10'h007);
    step(1'b0, 1'b1, 1'b0, 2'd1, 10'h007);
    chk("rst_acc0",  32'(acc0),  32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_car1",  32'(car1),  32'd0);
    step(1'b1, 1'b1, 1'b0, 2'd1, 10'h007);
    step(1'b1, 1'b1, 1'b0, 2'd1, 10'h007);
    chk("rst_held_run_idle", 32'(busy0), 32'd0);
    do_op(2'd1, 10'h010, 5, "add10");
    chk("post_rst_acc0", 32'(acc0), 32'h00000010);
    chk("post_rst_acc1", 32'(acc1), 32'h00000010);

    // Random traffic against the model
    ru = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      r  = ($urandom_range(0, 79) != 0);
      cl = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) ru = ~ru;
      step(r, ru, cl, 2'($urandom), IW'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
